afifo_read_arbiter: RTL and testbench

//   Round-robin read scheduler for NUM_FIFOS asynchronous FIFOs sharing one read clock domain.

---
 rtl/afifo_read_arbiter_if.sv | 37 +++
 rtl/afifo_read_arbiter.sv | 145 ++++++++++++++
 tb/tb_afifo_read_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_read_arbiter_if.sv
// Read-side bundle between an array of async FIFOs, the round-robin read
// arbiter and the downstream valid/ready consumer.
//   empty      : per-FIFO empty flags (bit i = FIFO i)
//   fifo_data  : per-FIFO registered read data, FIFO i in slice i
//   src_enable : per-FIFO arbitration mask, 1 = eligible
//   read_en_c  : combinational one-hot-or-zero read strobe to the FIFOs
//   data/src   : captured word and the index of the FIFO that supplied it
//   valid      : data/src valid; accepted when valid & ready
//   ready      : downstream accept
//   busy       : arbiter is not idle-searching
interface afifo_read_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FIFOS  = 4,
  parameter int unsigned SRC_WIDTH  = 2
);
  logic [NUM_FIFOS-1:0]            empty;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data;
  logic [NUM_FIFOS-1:0]            src_enable;
  logic [NUM_FIFOS-1:0]            read_en_c;
  logic [DATA_WIDTH-1:0]           data;
  logic [SRC_WIDTH-1:0]            src;
  logic                            valid;
  logic                            ready;
  logic                            busy;

  // Arbiter side.
  modport master (
    input  empty, fifo_data, src_enable, ready,
    output read_en_c, data, src, valid, busy
  );

  // FIFO array / consumer side.
  modport slave (
    output empty, fifo_data, src_enable, ready,
    input  read_en_c, data, src, valid, busy
  );
endinterface

// File: rtl/afifo_read_arbiter.sv
// Round-robin read scheduler for NUM_FIFOS async FIFOs in one read clock
// domain. Pulses the granted FIFO's read strobe, captures its registered
// output one cycle later and presents it on a valid/ready stream tagged with
// the source index. Up to MAX_BURST words are taken from one source before
// the grant rotates; the last granted source then has lowest priority.
//   clk   : read-domain clock (the FIFOs' read clock)
//   rst_n : asynchronous reset, active low
//   bus   : afifo_read_arbiter_if master modport (see interface header)
module afifo_read_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FIFOS  = 4,
  parameter int unsigned SRC_WIDTH  = 2,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  afifo_read_arbiter_if.master bus
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [SRC_WIDTH-1:0] LAST_RESET = SRC_WIDTH'(NUM_FIFOS - 1);
  localparam logic [CNT_WIDTH-1:0] BURST_LIMIT = CNT_WIDTH'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    CAPTURE = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SRC_WIDTH-1:0]   grant_q, grant_d;
  logic [SRC_WIDTH-1:0]   last_q, last_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SRC_WIDTH-1:0]   src_q, src_d;
  logic                   valid_q, valid_d;
  logic                   busy_q;

  logic [NUM_FIFOS-1:0]   eligible;
  logic [NUM_FIFOS-1:0]   read_en;
  logic                   found;
  logic [SRC_WIDTH-1:0]   win;
  logic [SRC_WIDTH-1:0]   cand;
  logic [DATA_WIDTH-1:0]  slice [NUM_FIFOS];

  assign eligible = bus.src_enable & ~bus.empty;

  // Unpack the flat FIFO data bus into per-source words.
  always_comb begin : unpack
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      slice[i] = bus.fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First eligible index after last_q, wrapping; the last grant is tried last.
  always_comb begin : search
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
      cand = SRC_WIDTH'((32'(last_q) + k) % NUM_FIFOS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and datapath decode.
  always_comb begin : fsm_next
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    read_en = '0;
    case (state_q)
      ARB: begin
        if (found) begin
          read_en[win] = 1'b1;
          grant_d      = win;
          last_d       = win;
          cnt_d        = CNT_ONE;
          state_d      = CAPTURE;
        end
      end
      CAPTURE: begin
        // FIFO output was loaded by the read strobe on the previous edge.
        data_d  = slice[grant_q];
        src_d   = grant_q;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (bus.ready) begin
          valid_d = 1'b0;
          if (eligible[grant_q] && (cnt_q < BURST_LIMIT)) begin
            read_en[grant_q] = 1'b1;
            cnt_d            = cnt_q + CNT_ONE;
            state_d          = CAPTURE;
          end else begin
            state_d = ARB;
          end
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
    if (!rst_n) begin
      state_q <= ARB;
      grant_q <= '0;
      last_q  <= LAST_RESET;
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != ARB);
    end
  end

  // Read strobe is forced low while reset is held so no FIFO word is popped.
  assign bus.read_en_c = read_en & {NUM_FIFOS{rst_n}};
  assign bus.data      = data_q;
  assign bus.src       = src_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_afifo_read_arbiter.sv
// Self-checking bench for afifo_read_arbiter: behavioural FIFO array,
// per-scenario tasks, and a transaction-level round-robin predictor.
module tb_afifo_read_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned NF = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned MB = 4;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  afifo_read_arbiter_if #(.DATA_WIDTH(DW), .NUM_FIFOS(NF), .SRC_WIDTH(SW)) bus ();

  afifo_read_arbiter #(.DATA_WIDTH(DW), .NUM_FIFOS(NF), .SRC_WIDTH(SW), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // FIFO array model: registered output loaded on a read strobe.
  logic [DW-1:0] fmem  [NF][DEPTH];
  logic [DW-1:0] fdout [NF];
  int unsigned   wr_ptr [NF];
  int unsigned   rd_ptr [NF];
  int            underflow = 0;

  for (genvar g = 0; g < NF; g++) begin : g_fifo
    assign bus.empty[g] = (wr_ptr[g] == rd_ptr[g]);
    assign bus.fifo_data[g*DW +: DW] = fdout[g];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (bus.read_en_c[i]) begin
        if (wr_ptr[i] == rd_ptr[i]) underflow++;
        else begin
          fdout[i]  <= fmem[i][rd_ptr[i] % DEPTH];
          rd_ptr[i] <= rd_ptr[i] + 1;
        end
      end
    end
  end

  int passed = 0;
  int total = 0;

  // Observation state filled by cycle().
  int            obs_src [$];
  logic [DW-1:0] obs_data [$];
  int            viol_onehot, viol_inelig, viol_stable;
  logic          stall_prev;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_src;
  logic [NF-1:0] s_re;
  logic          s_valid, s_busy;
  logic [DW-1:0] s_data;
  logic [SW-1:0] s_src;

  task automatic push(input int f, input logic [DW-1:0] v);
    fmem[f][wr_ptr[f] % DEPTH] = v;
    wr_ptr[f] = wr_ptr[f] + 1;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NF; i++) wr_ptr[i] = rd_ptr[i];
  endtask

  task automatic clear_obs();
    obs_src.delete();
    obs_data.delete();
    viol_onehot = 0;
    viol_inelig = 0;
    viol_stable = 0;
    stall_prev  = 1'b0;
  endtask

  // Sample settled pre-edge values, record handshakes, advance one clock.
  task automatic cycle();
    logic [NF-1:0] elig;
    #2;
    elig    = bus.src_enable & ~bus.empty;
    s_re    = bus.read_en_c;
    s_valid = bus.valid;
    s_busy  = bus.busy;
    s_data  = bus.data;
    s_src   = bus.src;
    if ($countones(s_re) > 1) viol_onehot++;
    if ((s_re & ~elig) != '0) viol_inelig++;
    if (stall_prev && (!s_valid || s_data !== prev_data || s_src !== prev_src)) viol_stable++;
    if (s_valid && bus.ready) begin
      obs_src.push_back(int'(s_src));
      obs_data.push_back(s_data);
    end
    stall_prev = s_valid && !bus.ready;
    prev_data  = s_data;
    prev_src   = s_src;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.src_enable = '1;
    bus.ready = 1'b1;
    clear_fifos();
    clear_obs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.src_enable = '1;
    bus.ready = 1'b1;
    clear_fifos();
    push(1, 32'h1111_2222);
    repeat (2) @(posedge clk);
    #3;
    total++; if (bus.read_en_c !== 4'b0000) $display("FAIL reset_read_en got %b want 0000", bus.read_en_c); else passed++;
    total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.data !== 32'h0) $display("FAIL reset_data got %h want 0", bus.data); else passed++;
    total++; if (bus.src !== 2'd0) $display("FAIL reset_src got %0d want 0", bus.src); else passed++;
    clear_fifos();
  endtask

  // Single source, three words: read strobe every other cycle, valid 2 cycles after grant.
  task automatic test_single();
    logic [NF-1:0] exp_re [8];
    logic          exp_v  [8];
    logic          exp_b  [8];
    logic [DW-1:0] words  [3];
    int            wi;
    reset_dut();
    exp_re = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    exp_v  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_b  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      push(2, words[i]);
    end
    wi = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      total++; if (s_re !== exp_re[c]) $display("FAIL single_read_en c%0d got %b want %b", c, s_re, exp_re[c]); else passed++;
      total++; if (s_valid !== exp_v[c]) $display("FAIL single_valid c%0d got %b want %b", c, s_valid, exp_v[c]); else passed++;
      total++; if (s_busy !== exp_b[c]) $display("FAIL single_busy c%0d got %b want %b", c, s_busy, exp_b[c]); else passed++;
      if (exp_v[c]) begin
        total++; if (s_data !== words[wi]) $display("FAIL single_data w%0d got %h want %h", wi, s_data, words[wi]); else passed++;
        total++; if (s_src !== 2'd2) $display("FAIL single_src w%0d got %0d want 2", wi, s_src); else passed++;
        wi++;
      end
    end
  endtask

  // Round-robin bursts from preloaded FIFOs under random back-pressure.
  task automatic test_bursts();
    int            depth [NF];
    int            rem   [NF];
    int            taken [NF];
    logic [DW-1:0] vals  [NF][16];
    int            exp_s [$];
    logic [DW-1:0] exp_d [$];
    int            last, pick, n, left, uf0;
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      uf0 = underflow;
      exp_s.delete();
      exp_d.delete();
      for (int i = 0; i < NF; i++) begin
        depth[i] = (r == 0) ? 8 : int'($urandom_range(0, 9));
        rem[i]   = depth[i];
        taken[i] = 0;
        for (int j = 0; j < depth[i]; j++) begin
          vals[i][j] = $urandom;
          push(i, vals[i][j]);
        end
      end
      // Predict: rotate from index 0, take min(MAX_BURST, remaining) per grant.
      last = NF - 1;
      left = 0;
      for (int i = 0; i < NF; i++) left += rem[i];
      while (left > 0) begin
        pick = -1;
        for (int k = 1; k <= NF; k++) begin
          if (pick < 0 && rem[(last + k) % NF] > 0) pick = (last + k) % NF;
        end
        n = (rem[pick] < MB) ? rem[pick] : MB;
        for (int j = 0; j < n; j++) begin
          exp_s.push_back(pick);
          exp_d.push_back(vals[pick][taken[pick] + j]);
        end
        taken[pick] += n;
        rem[pick]   -= n;
        left        -= n;
        last         = pick;
      end
      for (int c = 0; c < 800 && obs_src.size() < exp_s.size(); c++) begin
        bus.ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
      bus.ready = 1'b1;
      repeat (6) cycle();
      total++; if (obs_src.size() !== exp_s.size()) $display("FAIL bursts_count r%0d got %0d want %0d", r, obs_src.size(), exp_s.size()); else passed++;
      for (int k = 0; k < exp_s.size() && k < obs_src.size(); k++) begin
        total++;
        if (obs_src[k] !== exp_s[k] || obs_data[k] !== exp_d[k])
          $display("FAIL bursts_word r%0d k%0d got src%0d %h want src%0d %h", r, k, obs_src[k], obs_data[k], exp_s[k], exp_d[k]);
        else passed++;
      end
      total++; if (viol_onehot !== 0) $display("FAIL bursts_onehot r%0d got %0d violations want 0", r, viol_onehot); else passed++;
      total++; if (viol_inelig !== 0) $display("FAIL bursts_inelig r%0d got %0d violations want 0", r, viol_inelig); else passed++;
      total++; if (viol_stable !== 0) $display("FAIL bursts_stable r%0d got %0d violations want 0", r, viol_stable); else passed++;
      total++; if (underflow !== uf0) $display("FAIL bursts_underflow r%0d got %0d want %0d", r, underflow, uf0); else passed++;
    end
  endtask

  // Output holds while stalled; no word lost.
  task automatic test_stall();
    logic [DW-1:0] x, y;
    bit            seen;
    reset_dut();
    x = $urandom;
    y = $urandom;
    push(0, x);
    push(0, y);
    bus.ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      seen = s_valid;
    end
    total++; if (seen !== 1'b1) $display("FAIL stall_valid_timeout got %b want 1", seen); else passed++;
    for (int c = 0; c < 5; c++) begin
      cycle();
      total++;
      if (s_valid !== 1'b1 || s_data !== x || s_src !== 2'd0 || s_re !== 4'b0000)
        $display("FAIL stall_hold c%0d got v%b %h src%0d re%b want v1 %h src0 re0000", c, s_valid, s_data, s_src, s_re, x);
      else passed++;
    end
    bus.ready = 1'b1;
    for (int c = 0; c < 20 && obs_src.size() < 2; c++) cycle();
    total++; if (obs_src.size() !== 2) $display("FAIL stall_count got %0d want 2", obs_src.size()); else passed++;
    if (obs_src.size() == 2) begin
      total++; if (obs_data[0] !== x || obs_data[1] !== y) $display("FAIL stall_words got %h %h want %h %h", obs_data[0], obs_data[1], x, y); else passed++;
    end
    total++; if (wr_ptr[0] !== rd_ptr[0]) $display("FAIL stall_drained got %0d left want 0", wr_ptr[0] - rd_ptr[0]); else passed++;
  endtask

  // Clearing a source's enable mid-burst ends the burst after the word in flight.
  task automatic test_disable();
    logic [DW-1:0] a [6];
    logic [DW-1:0] b [2];
    int            pulses;
    reset_dut();
    for (int i = 0; i < 6; i++) begin a[i] = $urandom; push(1, a[i]); end
    for (int i = 0; i < 2; i++) begin b[i] = $urandom; push(2, b[i]); end
    pulses = 0;
    for (int c = 0; c < 100 && obs_src.size() < 4; c++) begin
      cycle();
      if (s_re[1]) pulses++;
      if (pulses == 2) bus.src_enable[1] = 1'b0;
    end
    total++; if (obs_src.size() !== 4) $display("FAIL disable_count got %0d want 4", obs_src.size()); else passed++;
    if (obs_src.size() == 4) begin
      total++; if (obs_src[0] !== 1 || obs_data[0] !== a[0]) $display("FAIL disable_w0 got src%0d %h want src1 %h", obs_src[0], obs_data[0], a[0]); else passed++;
      total++; if (obs_src[1] !== 1 || obs_data[1] !== a[1]) $display("FAIL disable_w1 got src%0d %h want src1 %h", obs_src[1], obs_data[1], a[1]); else passed++;
      total++; if (obs_src[2] !== 2 || obs_data[2] !== b[0]) $display("FAIL disable_w2 got src%0d %h want src2 %h", obs_src[2], obs_data[2], b[0]); else passed++;
      total++; if (obs_src[3] !== 2 || obs_data[3] !== b[1]) $display("FAIL disable_w3 got src%0d %h want src2 %h", obs_src[3], obs_data[3], b[1]); else passed++;
    end
    total++; if (wr_ptr[1] - rd_ptr[1] !== 32'd4) $display("FAIL disable_left got %0d want 4", wr_ptr[1] - rd_ptr[1]); else passed++;
  endtask

  // Reset during CAPTURE drops the word in flight and restarts the search at 0.
  task automatic test_reset_capture();
    logic [DW-1:0] d [3];
    logic [DW-1:0] c0;
    reset_dut();
    for (int i = 0; i < 3; i++) begin d[i] = $urandom; push(3, d[i]); end
    cycle();
    total++; if (s_re !== 4'b1000) $display("FAIL rstcap_grant got %b want 1000", s_re); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.read_en_c !== 4'b0000)
      $display("FAIL rstcap_async got v%b b%b re%b want v0 b0 re0000", bus.valid, bus.busy, bus.read_en_c);
    else passed++;
    c0 = $urandom;
    push(0, c0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_obs();
    @(posedge clk);
    #1;
    for (int c = 0; c < 60 && obs_src.size() < 3; c++) cycle();
    total++; if (obs_src.size() !== 3) $display("FAIL rstcap_count got %0d want 3", obs_src.size()); else passed++;
    if (obs_src.size() == 3) begin
      total++; if (obs_src[0] !== 0 || obs_data[0] !== c0) $display("FAIL rstcap_w0 got src%0d %h want src0 %h", obs_src[0], obs_data[0], c0); else passed++;
      total++; if (obs_src[1] !== 3 || obs_data[1] !== d[1]) $display("FAIL rstcap_w1 got src%0d %h want src3 %h", obs_src[1], obs_data[1], d[1]); else passed++;
      total++; if (obs_src[2] !== 3 || obs_data[2] !== d[2]) $display("FAIL rstcap_w2 got src%0d %h want src3 %h", obs_src[2], obs_data[2], d[2]); else passed++;
    end
  endtask

  task automatic test_idle();
    reset_dut();
    for (int c = 0; c < 20; c++) begin
      cycle();
      total++;
      if ({s_re, s_busy, s_valid} !== 6'b0)
        $display("FAIL idle c%0d got re%b busy%b valid%b want all 0", c, s_re, s_busy, s_valid);
      else passed++;
    end
  endtask

  // Random pushes, masks and back-pressure; each source delivers its own words in order.
  task automatic test_random_mask();
    int unsigned seqn [NF];
    int unsigned nxt  [NF];
    int          pushed, f, bad, uf0;
    logic [DW-1:0] want;
    reset_dut();
    uf0 = underflow;
    pushed = 0;
    for (int i = 0; i < NF; i++) begin seqn[i] = 0; nxt[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        f = int'($urandom_range(0, NF - 1));
        if (wr_ptr[f] - rd_ptr[f] < 48) begin
          push(f, {8'(f), 24'(seqn[f])});
          seqn[f]++;
          pushed++;
        end
      end
      if ($urandom_range(0, 7) == 0) bus.src_enable = 4'($urandom);
      bus.ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.src_enable = '1;
    bus.ready = 1'b1;
    for (int c = 0; c < 1500 && obs_src.size() < pushed; c++) cycle();
    repeat (4) cycle();
    total++; if (obs_src.size() !== pushed) $display("FAIL rand_count got %0d want %0d", obs_src.size(), pushed); else passed++;
    bad = 0;
    for (int k = 0; k < obs_src.size(); k++) begin
      want = {8'(obs_src[k]), 24'(nxt[obs_src[k]])};
      if (obs_data[k] !== want) begin
        if (bad == 0) $display("FAIL rand_order k%0d got %h want %h", k, obs_data[k], want);
        bad++;
      end
      nxt[obs_src[k]]++;
    end
    total++; if (bad !== 0) $display("FAIL rand_order_total got %0d bad words want 0", bad); else passed++;
    total++; if (viol_onehot !== 0) $display("FAIL rand_onehot got %0d want 0", viol_onehot); else passed++;
    total++; if (viol_inelig !== 0) $display("FAIL rand_inelig got %0d want 0", viol_inelig); else passed++;
    total++; if (viol_stable !== 0) $display("FAIL rand_stable got %0d want 0", viol_stable); else passed++;
    total++; if (underflow !== uf0) $display("FAIL rand_underflow got %0d want %0d", underflow, uf0); else passed++;
  endtask

  initial begin
    bus.src_enable = '1;
    bus.ready = 1'b1;
    for (int i = 0; i < NF; i++) fdout[i] = '0;
    clear_obs();
    test_reset();
    test_single();
    test_bursts();
    test_stall();
    test_disable();
    test_reset_capture();
    test_idle();
    test_random_mask();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
